// File: rtl/led_shift_if.sv
// led_shift_if: user-side load handshake plus the serial chain pins of led_shift_out.
// The master drives the parallel word, and the slave drives the shift-register header.
interface led_shift_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              ready;
  logic              ser_out;
  logic              ser_clk;
  logic              latch;
  logic              done;

  modport master (
    output data_in, load,
    input  ready, ser_out, ser_clk, latch, done
  );

  modport slave (
    input  data_in, load,
    output ready, ser_out, ser_clk, latch, done
  );
endinterface

// File: rtl/led_shift_out.sv
// led_shift_out: parallel-to-serial driver for a 74HC595-style chain (MSB first, then latch strobe).
// Define LED_SHIFT_REFRESH_EN to resend the last word after REFRESH idle cycles.
module led_shift_out #(
`ifdef LED_SHIFT_REFRESH_EN
  parameter int REFRESH = 1024,
`endif
  parameter int DATA_W  = 16,
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  led_shift_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_END  = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DONE} state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  bit_cnt_nxt;
  logic [DIV_W-1:0]  div;
  logic [DIV_W-1:0]  div_nxt;
  logic              phase;
  logic              phase_nxt;
  logic              tick;
  logic              accept;
  logic [DATA_W-1:0] frame_word;
  logic              ready_q;
  logic              ser_out_q;
  logic              ser_clk_q;
  logic              latch_q;
  logic              done_q;
  logic              ready_nxt;
  logic              ser_out_nxt;
  logic              ser_clk_nxt;
  logic              latch_nxt;
  logic              done_nxt;

  assign tick = (div == DIV_END);

`ifdef LED_SHIFT_REFRESH_EN
  localparam int IDLE_W = (REFRESH > 1) ? $clog2(REFRESH) : 1;
  localparam logic [IDLE_W-1:0] IDLE_END = IDLE_W'(REFRESH - 1);

  logic [DATA_W-1:0] hold;
  logic              have_hold;
  logic [IDLE_W-1:0] idle_cnt;
  logic              refresh_fire;

  assign refresh_fire = (state == IDLE) && have_hold && (idle_cnt == IDLE_END);
  assign accept       = (state == IDLE) && (bus.load || refresh_fire);
  assign frame_word   = bus.load ? bus.data_in : hold;

  // The idle counter only runs once a word has been sent, and any accept restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold      <= '0;
      have_hold <= 1'b0;
      idle_cnt  <= '0;
    end else begin
      if ((state == IDLE) && bus.load) begin
        hold      <= bus.data_in;
        have_hold <= 1'b1;
      end
      if ((state != IDLE) || accept)
        idle_cnt <= '0;
      else if (have_hold)
        idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign accept     = (state == IDLE) && bus.load;
  assign frame_word = bus.data_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      div       <= '0;
      phase     <= 1'b0;
      ready_q   <= 1'b1;
      ser_out_q <= 1'b0;
      ser_clk_q <= 1'b0;
      latch_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= next_state;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      div       <= div_nxt;
      phase     <= phase_nxt;
      ready_q   <= ready_nxt;
      ser_out_q <= ser_out_nxt;
      ser_clk_q <= ser_clk_nxt;
      latch_q   <= latch_nxt;
      done_q    <= done_nxt;
    end
  end

  // Each bit spends CLK_DIV cycles with ser_clk low, then CLK_DIV cycles with it high.
  always_comb begin
    next_state  = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_nxt     = div;
    phase_nxt   = phase;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state  = SHIFT;
          shreg_nxt   = frame_word;
          bit_cnt_nxt = LAST_BIT;
          div_nxt     = '0;
          phase_nxt   = 1'b0;
        end
      end
      SHIFT: begin
        if (!tick) begin
          div_nxt = div + 1'b1;
        end else begin
          div_nxt = '0;
          if (!phase) begin
            phase_nxt = 1'b1;
          end else begin
            phase_nxt = 1'b0;
            if (bit_cnt == '0) begin
              next_state = LATCH;
            end else begin
              bit_cnt_nxt = bit_cnt - 1'b1;
              shreg_nxt   = {shreg[DATA_W-2:0], 1'b0};
            end
          end
        end
      end
      LATCH: begin
        if (!tick) begin
          div_nxt = div + 1'b1;
        end else begin
          div_nxt    = '0;
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so that every pin comes straight from a flop.
  always_comb begin
    ready_nxt   = (next_state == IDLE);
    latch_nxt   = (next_state == LATCH);
    done_nxt    = (next_state == DONE);
    ser_clk_nxt = (next_state == SHIFT) && phase_nxt;
    ser_out_nxt = (next_state == SHIFT) ? shreg_nxt[DATA_W-1] : ser_out_q;
  end

  assign bus.ready   = ready_q;
  assign bus.ser_out = ser_out_q;
  assign bus.ser_clk = ser_clk_q;
  assign bus.latch   = latch_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_led_shift_out.sv
// tb_led_shift_out: directed bench for led_shift_out (8-bit/div-2 and 16-bit/div-1 instances).
// With LED_SHIFT_REFRESH_EN, a third instance with REFRESH=50 checks the automatic resend.
module tb_led_shift_out;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  led_shift_if #(.DATA_W(8))  bus_a ();
  led_shift_if #(.DATA_W(16)) bus_b ();

  led_shift_out #(.DATA_W(8), .CLK_DIV(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  led_shift_out #(.DATA_W(16), .CLK_DIV(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

`ifdef LED_SHIFT_REFRESH_EN
  led_shift_if #(.DATA_W(8)) bus_c ();
  led_shift_out #(.REFRESH(50), .DATA_W(8), .CLK_DIV(2)) dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
`endif

  // Packed observation: {ready, ser_out, ser_clk, latch, done}
  function automatic logic [4:0] obs(input int sel);
    logic [4:0] v;
    v = 5'b0;
    case (sel)
      0: v = {bus_a.ready, bus_a.ser_out, bus_a.ser_clk, bus_a.latch, bus_a.done};
      1: v = {bus_b.ready, bus_b.ser_out, bus_b.ser_clk, bus_b.latch, bus_b.done};
`ifdef LED_SHIFT_REFRESH_EN
      2: v = {bus_c.ready, bus_c.ser_out, bus_c.ser_clk, bus_c.latch, bus_c.done};
`endif
      default: v = 5'b0;
    endcase
    return v;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic [15:0] data, input logic ld);
    case (sel)
      0: begin bus_a.data_in = data[7:0]; bus_a.load = ld; end
      1: begin bus_b.data_in = data;      bus_b.load = ld; end
`ifdef LED_SHIFT_REFRESH_EN
      2: begin bus_c.data_in = data[7:0]; bus_c.load = ld; end
`endif
      default: ;
    endcase
  endtask

  task automatic drop_load(input int sel);
    case (sel)
      0: begin bus_a.load = 1'b0; bus_a.data_in = ~bus_a.data_in; end
      1: begin bus_b.load = 1'b0; bus_b.data_in = ~bus_b.data_in; end
`ifdef LED_SHIFT_REFRESH_EN
      2: begin bus_c.load = 1'b0; bus_c.data_in = ~bus_c.data_in; end
`endif
      default: ;
    endcase
  endtask

  // Called #1 after the accept edge; walks the frame cycle by cycle until ready returns.
  task automatic frame_check(input int sel, input int dw, input int cd, input logic [15:0] word,
                             input bit keep_load, input int stop_k, input string tag);
    int         shift_len;
    int         last_k;
    int         b;
    logic [4:0] exp;
    logic [4:0] got;
    logic [15:0] cap;
    logic       prev_clk;
    shift_len = 2 * cd * dw;
    last_k    = shift_len + cd + 1;
    if (stop_k >= 0 && stop_k < last_k) last_k = stop_k;
    cap      = '0;
    prev_clk = 1'b0;
    for (int k = 0; k <= last_k; k++) begin
      if (k == 0 && !keep_load) drop_load(sel);
      if (k < shift_len) begin
        b   = dw - 1 - k / (2 * cd);
        exp = {1'b0, word[b], ((k % (2 * cd)) >= cd), 1'b0, 1'b0};
      end else if (k < shift_len + cd) begin
        exp = {1'b0, word[0], 3'b010};
      end else if (k == shift_len + cd) begin
        exp = {1'b0, word[0], 3'b001};
      end else begin
        exp = {1'b1, word[0], 3'b000};
      end
      got = obs(sel);
      check_output($sformatf("%s k=%0d", tag, k), {27'd0, got}, {27'd0, exp});
      if (got[2] && !prev_clk) cap = {cap[14:0], got[3]};
      prev_clk = got[2];
      if (k < last_k) begin
        @(posedge clk);
        #1;
      end
    end
    if (stop_k < 0) check_output({tag, " sampled word"}, {16'd0, cap}, {16'd0, word});
  endtask

  task automatic accept_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int low_cnt;
    rst_n = 1'b0;
    apply_stimulus(0, 16'h0000, 1'b0);
    apply_stimulus(1, 16'h0000, 1'b0);
`ifdef LED_SHIFT_REFRESH_EN
    apply_stimulus(2, 16'h0000, 1'b0);
`endif
    @(posedge clk);
    #1;
    check_output("reset a", {27'd0, obs(0)}, 32'h10);
    check_output("reset b", {27'd0, obs(1)}, 32'h10);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] frame 8'hA5, single-cycle load");
    apply_stimulus(0, 16'h00A5, 1'b1);
    accept_edge();
    frame_check(0, 8, 2, 16'h00A5, 1'b0, -1, "a5");

    $display("[TB] frame 8'h3C with load held and data changed to 8'hFF");
    @(posedge clk);
    #1;
    apply_stimulus(0, 16'h003C, 1'b1);
    accept_edge();
    apply_stimulus(0, 16'h00FF, 1'b1);
    frame_check(0, 8, 2, 16'h003C, 1'b1, -1, "3c");
    accept_edge();
    frame_check(0, 8, 2, 16'h00FF, 1'b0, -1, "ff follow");

    $display("[TB] back-to-back frames of 8'h81");
    @(posedge clk);
    #1;
    apply_stimulus(0, 16'h0081, 1'b1);
    accept_edge();
    frame_check(0, 8, 2, 16'h0081, 1'b1, -1, "81 first");
    accept_edge();
    frame_check(0, 8, 2, 16'h0081, 1'b0, -1, "81 second");

    $display("[TB] reset during bit 4");
    @(posedge clk);
    #1;
    apply_stimulus(0, 16'h00C3, 1'b1);
    accept_edge();
    frame_check(0, 8, 2, 16'h00C3, 1'b0, 14, "c3 partial");
    rst_n = 1'b0;
    #1;
    check_output("mid-frame reset immediate", {27'd0, obs(0)}, 32'h10);
    @(posedge clk);
    #1;
    check_output("mid-frame reset held", {27'd0, obs(0)}, 32'h10);
    rst_n = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (obs(0) !== 5'b10000) low_cnt++;
    end
    check_output("idle after reset, no done", low_cnt, 0);
    apply_stimulus(0, 16'h0096, 1'b1);
    accept_edge();
    frame_check(0, 8, 2, 16'h0096, 1'b0, -1, "96 after reset");

    $display("[TB] 16-bit frame 16'h0001 with CLK_DIV=1");
    apply_stimulus(1, 16'h0001, 1'b1);
    accept_edge();
    frame_check(1, 16, 1, 16'h0001, 1'b0, -1, "b 0001");

`ifdef LED_SHIFT_REFRESH_EN
    $display("[TB] refresh of 8'h5A every 85 cycles");
    low_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (obs(2) !== 5'b10000) low_cnt++;
    end
    check_output("no refresh before first load", low_cnt, 0);
    apply_stimulus(2, 16'h005A, 1'b1);
    accept_edge();
    frame_check(2, 8, 2, 16'h005A, 1'b0, -1, "5a sent");
    for (int r = 0; r < 2; r++) begin
      low_cnt = 0;
      for (int i = 1; i < 50; i++) begin
        @(posedge clk);
        #1;
        if (obs(2) !== {1'b1, 1'b0, 3'b000}) low_cnt++;
      end
      check_output($sformatf("idle gap %0d", r), low_cnt, 0);
      accept_edge();
      frame_check(2, 8, 2, 16'h005A, 1'b0, -1, $sformatf("5a refresh %0d", r));
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
